// File: rtl/alu3_issue_ctrl.sv
// rtl/alu3_issue_ctrl.sv - issue/capture sequencer in front of the 3-bit combinational ALU
module alu3_issue_ctrl #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_a,
  input  logic [2:0]         cmd_b,
  input  logic [2:0]         cmd_sel,
  input  logic               cmd_use_acc,
  output logic [2:0]         alu_a,
  output logic [2:0]         alu_b,
  output logic [2:0]         alu_sel,
  input  logic [2:0]         alu_result,
  input  logic [4:0]         alu_flags,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2:0]         rsp_result,
  output logic [4:0]         rsp_flags,
  output logic               rsp_illegal,
  output logic [2:0]         acc,
  output logic [COUNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic sel_writes_acc;

  // Only ADD, SUB, AND, OR produce a value worth chaining; compares and 000 do not.
  assign sel_writes_acc = (alu_sel >= 3'd1) && (alu_sel <= 3'd4);

  assign cmd_ready = (state == IDLE) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      alu_a       <= 3'd0;
      alu_b       <= 3'd0;
      alu_sel     <= 3'd0;
      acc         <= 3'd0;
      op_count    <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= 3'd0;
      rsp_flags   <= 5'd0;
      rsp_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            alu_a   <= cmd_use_acc ? acc : cmd_a;
            alu_b   <= cmd_b;
            alu_sel <= cmd_sel;
            state   <= EXEC;
          end
        end
        EXEC: begin
          rsp_result  <= alu_result;
          rsp_flags   <= alu_flags;
          rsp_illegal <= (alu_sel == 3'd0);
          rsp_valid   <= 1'b1;
          if (sel_writes_acc) begin
            acc <= alu_result;
          end
          state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (op_count != COUNT_MAX) begin
              op_count <= op_count + COUNT_ONE;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu3_issue_ctrl.sv
// tb/tb_alu3_issue_ctrl.sv - directed bench for alu3_issue_ctrl with a behavioural ALU
module tb_alu3_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready, cmd_ready2;
  logic [2:0] cmd_a, cmd_b, cmd_sel;
  logic       cmd_use_acc;
  logic [2:0] alu_a, alu_b, alu_sel;
  logic [2:0] alu_a2, alu_b2, alu_sel2;
  logic [2:0] alu_result;
  logic [4:0] alu_flags;
  logic       rsp_valid, rsp_valid2;
  logic       rsp_ready;
  logic [2:0] rsp_result, rsp_result2;
  logic [4:0] rsp_flags, rsp_flags2;
  logic       rsp_illegal, rsp_illegal2;
  logic [2:0] acc, acc2;
  logic [7:0] op_count;
  logic [1:0] op_count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu3_issue_ctrl #(.COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_illegal(rsp_illegal), .acc(acc), .op_count(op_count)
  );

  // Narrow-counter twin: same stimulus, only op_count saturation differs.
  alu3_issue_ctrl #(.COUNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready2),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel), .cmd_use_acc(cmd_use_acc),
    .alu_a(alu_a2), .alu_b(alu_b2), .alu_sel(alu_sel2),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_result(rsp_result2),
    .rsp_flags(rsp_flags2), .rsp_illegal(rsp_illegal2), .acc(acc2), .op_count(op_count2)
  );

  always_comb begin
    logic [3:0] sum;
    logic       c, z, eq, lt, gt;
    logic [2:0] r;
    sum = 4'd0;
    c = 1'b0; z = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0;
    r = 3'd0;
    case (alu_sel)
      3'd1: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; r = sum[2:0]; c = sum[3]; z = (r == 3'd0); end
      3'd2: begin r = alu_a - alu_b; c = (alu_a < alu_b); z = (r == 3'd0); end
      3'd3: begin r = alu_a & alu_b; z = (r == 3'd0); end
      3'd4: begin r = alu_a | alu_b; z = (r == 3'd0); end
      3'd5: eq = (alu_a == alu_b);
      3'd6: lt = (alu_a < alu_b);
      3'd7: gt = (alu_a > alu_b);
      default: z = 1'b1;
    endcase
    alu_result = r;
    alu_flags  = {c, z, eq, lt, gt};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] a, input logic [2:0] b,
                       input logic [2:0] sel, input logic use_acc);
    cmd_valid   = 1'b1;
    cmd_a       = a;
    cmd_b       = b;
    cmd_sel     = sel;
    cmd_use_acc = use_acc;
    tick();
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = 3'd0; cmd_b = 3'd0; cmd_sel = 3'd0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0;
    tick();
    tick();
    chk("ready_in_reset", {7'd0, cmd_ready}, 8'd0);
    rst = 1'b0;
    #1;
    chk("reset_ready", {7'd0, cmd_ready}, 8'd1);
    chk("reset_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    chk("reset_alu", {alu_a, alu_b, 2'b00}, 8'd0);
    chk("reset_alu_sel", {5'd0, alu_sel}, 8'd0);
    chk("reset_acc", {5'd0, acc}, 8'd0);
    chk("reset_count", op_count, 8'd0);
    chk("reset_rsp", {rsp_result, rsp_flags}, 8'd0);

    // ADD 5+4 with issue timing
    cmd_valid = 1'b1; cmd_a = 3'd5; cmd_b = 3'd4; cmd_sel = 3'd1; cmd_use_acc = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("t1_alu_a", {5'd0, alu_a}, 8'd5);
    chk("t1_alu_b", {5'd0, alu_b}, 8'd4);
    chk("t1_alu_sel", {5'd0, alu_sel}, 8'd1);
    chk("t1_exec_valid", {7'd0, rsp_valid}, 8'd0);
    chk("t1_exec_ready", {7'd0, cmd_ready}, 8'd0);
    tick();
    chk("t1_rsp_valid", {7'd0, rsp_valid}, 8'd1);
    chk("t1_result", {5'd0, rsp_result}, 8'd1);
    chk("t1_flags", {3'd0, rsp_flags}, 8'h10);
    chk("t1_acc", {5'd0, acc}, 8'd1);
    chk("t1_illegal", {7'd0, rsp_illegal}, 8'd0);
    chk("t1_count_pre", op_count, 8'd0);

    // Backpressure
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_valid", {7'd0, rsp_valid}, 8'd1);
      chk("bp_rsp", {rsp_result, rsp_flags}, {3'd1, 5'h10});
      chk("bp_ready", {7'd0, cmd_ready}, 8'd0);
    end
    take_rsp();
    chk("bp_release_valid", {7'd0, rsp_valid}, 8'd0);
    chk("bp_release_ready", {7'd0, cmd_ready}, 8'd1);
    chk("t1_count", op_count, 8'd1);

    // Chain through the accumulator
    do_op(3'd3, 3'd3, 3'd2, 1'b0);
    chk("sub_result", {5'd0, rsp_result}, 8'd0);
    chk("sub_flags", {3'd0, rsp_flags}, 8'h08);
    chk("sub_acc", {5'd0, acc}, 8'd0);
    take_rsp();
    do_op(3'd7, 3'd2, 3'd1, 1'b1);
    chk("chain_alu_a", {5'd0, alu_a}, 8'd0);
    chk("chain_result", {5'd0, rsp_result}, 8'd2);
    chk("chain_flags", {3'd0, rsp_flags}, 8'h00);
    chk("chain_acc", {5'd0, acc}, 8'd2);
    take_rsp();

    // Compare leaves acc alone
    do_op(3'd2, 3'd3, 3'd1, 1'b0);
    chk("acc5", {5'd0, acc}, 8'd5);
    take_rsp();
    do_op(3'd2, 3'd6, 3'd6, 1'b0);
    chk("lt_flags", {3'd0, rsp_flags}, 8'h02);
    chk("lt_result", {5'd0, rsp_result}, 8'd0);
    chk("lt_acc", {5'd0, acc}, 8'd5);
    take_rsp();

    // Illegal opcode
    do_op(3'd1, 3'd2, 3'd0, 1'b0);
    chk("ill_flag", {7'd0, rsp_illegal}, 8'd1);
    chk("ill_result", {5'd0, rsp_result}, 8'd0);
    chk("ill_flags", {3'd0, rsp_flags}, 8'h08);
    chk("ill_acc", {5'd0, acc}, 8'd5);
    take_rsp();
    do_op(3'd1, 3'd2, 3'd4, 1'b0);
    chk("legal_after_ill", {7'd0, rsp_illegal}, 8'd0);
    chk("or_result", {5'd0, rsp_result}, 8'd3);
    chk("or_acc", {5'd0, acc}, 8'd3);
    take_rsp();
    chk("count7", op_count, 8'd7);
    chk("count_sat2", {6'd0, op_count2}, 8'd3);

    // Reset while in EXEC drops the operation
    cmd_valid = 1'b1; cmd_a = 3'd6; cmd_b = 3'd1; cmd_sel = 3'd1; cmd_use_acc = 1'b0;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", {7'd0, rsp_valid}, 8'd0);
    chk("mid_rst_ready", {7'd0, cmd_ready}, 8'd1);
    chk("mid_rst_alu", {alu_a, alu_b, 2'b00}, 8'd0);
    chk("mid_rst_acc", {5'd0, acc}, 8'd0);
    chk("mid_rst_rsp", {rsp_result, rsp_flags}, 8'd0);
    chk("mid_rst_count", op_count, 8'd0);
    tick();
    chk("mid_rst_no_rsp", {7'd0, rsp_valid}, 8'd0);

    // Five ops: wide counter 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      do_op(3'd1, 3'd1, 3'd3, 1'b0);
      take_rsp();
    end
    chk("count5", op_count, 8'd5);
    chk("count2_sat", {6'd0, op_count2}, 8'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
